// File: rtl/g10_pcs_pkg.sv
// Shared 10G PCS definitions for 66b block lock.
// Contents: lock FSM state enum, sync-header codes, default window sizes,
// and a sync-header validity helper.
package g10_pcs_pkg;

  localparam int unsigned SH_CNT_MAX_DEF     = 64;
  localparam int unsigned SH_INVALID_MAX_DEF = 16;
  localparam int unsigned SETTLE_BLOCKS_DEF  = 4;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  typedef enum logic [2:0] {
    LOCK_INIT,
    TEST_SH,
    SLIP,
    SLIP_WAIT,
    SETTLE
  } lock_state_e;

  // Only the two transition codes are legal sync headers.
  function automatic logic sh_is_valid(input logic [1:0] sh);
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/g10_block_lock_ctrl.sv
// 66b block lock controller: hunts for sync-header alignment by requesting
// one-bit gearbox slips, declares lock after a clean window and drops lock
// when too many invalid headers appear within one window.
// Ports:
//   clk_ref          - clock, rising edge
//   rst_ref          - asynchronous active-low reset
//   enable_i         - low holds the FSM in LOCK_INIT
//   sh_valid_i/sh_i  - sync header strobe and bits
//   slip_o           - one-cycle slip request to the gearbox
//   slip_done_i      - gearbox has applied the slip
//   block_lock_o     - block alignment achieved
//   lock_loss_cnt_o  - saturating count of lock-to-unlock transitions
module g10_block_lock_ctrl
  import g10_pcs_pkg::*;
#(
  parameter int unsigned SH_CNT_MAX     = SH_CNT_MAX_DEF,
  parameter int unsigned SH_INVALID_MAX = SH_INVALID_MAX_DEF,
  parameter int unsigned SETTLE_BLOCKS  = SETTLE_BLOCKS_DEF
) (
  input  logic       clk_ref,
  input  logic       rst_ref,
  input  logic       enable_i,
  input  logic       sh_valid_i,
  input  logic [1:0] sh_i,
  output logic       slip_o,
  input  logic       slip_done_i,
  output logic       block_lock_o,
  output logic [7:0] lock_loss_cnt_o
);

  localparam int unsigned SH_CNT_W = $clog2(SH_CNT_MAX + 1);
  localparam int unsigned INV_W    = $clog2(SH_INVALID_MAX + 1);
  localparam int unsigned SET_W    = $clog2(SETTLE_BLOCKS + 1);

  localparam logic [SH_CNT_W-1:0] SH_CNT_LAST = SH_CNT_W'(SH_CNT_MAX);
  localparam logic [INV_W-1:0]    INV_LAST    = INV_W'(SH_INVALID_MAX);
  localparam logic [SET_W-1:0]    SET_LAST    = SET_W'(SETTLE_BLOCKS);

  lock_state_e         state_q, state_d;
  logic [SH_CNT_W-1:0] sh_cnt_q, sh_cnt_d, sh_cnt_inc;
  logic [INV_W-1:0]    inv_cnt_q, inv_cnt_d, inv_cnt_inc;
  logic [SET_W-1:0]    set_cnt_q, set_cnt_d, set_cnt_inc;
  logic                lock_q, lock_d;
  logic                slip_q, slip_d;
  logic [7:0]          loss_q, loss_d, loss_inc;
  logic                sh_bad;

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    sh_cnt_d    = sh_cnt_q;
    inv_cnt_d   = inv_cnt_q;
    set_cnt_d   = set_cnt_q;
    lock_d      = lock_q;
    slip_d      = 1'b0;
    loss_d      = loss_q;
    sh_bad      = !sh_is_valid(sh_i);
    sh_cnt_inc  = sh_cnt_q + SH_CNT_W'(1);
    inv_cnt_inc = inv_cnt_q + INV_W'(1);
    set_cnt_inc = set_cnt_q + SET_W'(1);
    loss_inc    = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;

    if (!enable_i) begin
      // Disable overrides every state; dropping a held lock counts as a loss.
      state_d   = LOCK_INIT;
      sh_cnt_d  = '0;
      inv_cnt_d = '0;
      set_cnt_d = '0;
      lock_d    = 1'b0;
      if (lock_q) loss_d = loss_inc;
    end else begin
      case (state_q)
        LOCK_INIT: begin
          sh_cnt_d  = '0;
          inv_cnt_d = '0;
          lock_d    = 1'b0;
          state_d   = TEST_SH;
        end
        TEST_SH: begin
          if (sh_valid_i) begin
            if (!lock_q) begin
              if (sh_bad) begin
                state_d = SLIP;
                slip_d  = 1'b1;
              end else if (sh_cnt_inc == SH_CNT_LAST) begin
                lock_d    = 1'b1;
                sh_cnt_d  = '0;
                inv_cnt_d = '0;
              end else begin
                sh_cnt_d = sh_cnt_inc;
              end
            end else begin
              // Invalid threshold is checked before the window end.
              if (sh_bad && (inv_cnt_inc == INV_LAST)) begin
                state_d = SLIP;
                slip_d  = 1'b1;
                lock_d  = 1'b0;
                loss_d  = loss_inc;
              end else if (sh_cnt_inc == SH_CNT_LAST) begin
                sh_cnt_d  = '0;
                inv_cnt_d = '0;
              end else begin
                sh_cnt_d = sh_cnt_inc;
                if (sh_bad) inv_cnt_d = inv_cnt_inc;
              end
            end
          end
        end
        SLIP: begin
          // slip_done_i here belongs to no request yet and is dropped.
          sh_cnt_d  = '0;
          inv_cnt_d = '0;
          state_d   = SLIP_WAIT;
        end
        SLIP_WAIT: begin
          if (slip_done_i) begin
            set_cnt_d = '0;
            state_d   = SETTLE;
          end
        end
        SETTLE: begin
          if (sh_valid_i) begin
            if (set_cnt_inc == SET_LAST) begin
              set_cnt_d = '0;
              state_d   = TEST_SH;
            end else begin
              set_cnt_d = set_cnt_inc;
            end
          end
        end
        default: state_d = LOCK_INIT;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk_ref or negedge rst_ref) begin
    if (!rst_ref) begin
      state_q   <= LOCK_INIT;
      sh_cnt_q  <= '0;
      inv_cnt_q <= '0;
      set_cnt_q <= '0;
      lock_q    <= 1'b0;
      slip_q    <= 1'b0;
      loss_q    <= '0;
    end else begin
      state_q   <= state_d;
      sh_cnt_q  <= sh_cnt_d;
      inv_cnt_q <= inv_cnt_d;
      set_cnt_q <= set_cnt_d;
      lock_q    <= lock_d;
      slip_q    <= slip_d;
      loss_q    <= loss_d;
    end
  end

  assign slip_o          = slip_q;
  assign block_lock_o    = lock_q;
  assign lock_loss_cnt_o = loss_q;

endmodule

// File: tb/tb_g10_block_lock_ctrl.sv
// Bench for g10_block_lock_ctrl: a vector table plus directed sequences for
// lock, slip/settle, lock loss, lock hold, coincident events, reset during
// SLIP_WAIT and lock-loss counter saturation.
module tb_g10_block_lock_ctrl;
  import g10_pcs_pkg::*;

  logic       clk_ref = 1'b0;
  logic       rst_ref = 1'b0;
  logic       enable_i = 1'b0;
  logic       sh_valid_i = 1'b0;
  logic [1:0] sh_i = SH_DATA;
  logic       slip_done_i = 1'b0;
  logic       slip_o;
  logic       block_lock_o;
  logic [7:0] lock_loss_cnt_o;

  g10_block_lock_ctrl dut (
    .clk_ref         (clk_ref),
    .rst_ref         (rst_ref),
    .enable_i        (enable_i),
    .sh_valid_i      (sh_valid_i),
    .sh_i            (sh_i),
    .slip_o          (slip_o),
    .slip_done_i     (slip_done_i),
    .block_lock_o    (block_lock_o),
    .lock_loss_cnt_o (lock_loss_cnt_o)
  );

  always #5 clk_ref = ~clk_ref;

  typedef struct packed {
    logic       slip;
    logic       lock;
    logic [7:0] loss;
  } exp_t;

  typedef struct {
    logic       en;
    logic       v;
    logic [1:0] sh;
    logic       sd;
    logic       e_slip;
    logic       e_lock;
    int         rep;
  } vec_t;

  exp_t       exp_q[$];
  logic [7:0] exp_loss = 8'd0;
  int         total = 0;
  int         bad = 0;

  task automatic check(input string name, input exp_t act, input exp_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got slip=%b lock=%b loss=%0d, expected slip=%b lock=%b loss=%0d",
               name, act.slip, act.lock, act.loss, exp.slip, exp.lock, exp.loss);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, compare.
  task automatic cyc(input logic en, input logic v, input logic [1:0] sh, input logic sd,
                     input logic e_slip, input logic e_lock, input string name);
    exp_t e;
    enable_i    = en;
    sh_valid_i  = v;
    sh_i        = sh;
    slip_done_i = sd;
    exp_q.push_back('{slip: e_slip, lock: e_lock, loss: exp_loss});
    @(posedge clk_ref);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check(name, {slip_o, block_lock_o, lock_loss_cnt_o}, e);
    end
  endtask

  task automatic do_reset();
    enable_i    = 1'b0;
    sh_valid_i  = 1'b0;
    slip_done_i = 1'b0;
    rst_ref     = 1'b0;
    exp_loss    = 8'd0;
    #3;
    check("reset_outputs", {slip_o, block_lock_o, lock_loss_cnt_o}, '0);
    repeat (2) @(posedge clk_ref);
    @(negedge clk_ref);
    rst_ref = 1'b1;
  endtask

  // From LOCK_INIT: enable, then 64 valid headers; lock appears after the 64th.
  task automatic get_lock(input logic sd);
    cyc(1'b1, 1'b0, SH_DATA, sd, 1'b0, 1'b0, "lock_enable");
    for (int k = 1; k <= 64; k++)
      cyc(1'b1, 1'b1, (k % 2 == 1) ? SH_DATA : SH_CTRL, sd, 1'b0, (k == 64), "lock_hdr");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    // Unlocked slip: invalid 10th header, slip_done during slip_o ignored,
    // SLIP_WAIT ignores headers, 4 invalid headers discarded in SETTLE,
    // then a fresh 64-header window locks.
    tbl[0] = '{1'b1, 1'b0, SH_DATA, 1'b0, 1'b0, 1'b0, 1};
    tbl[1] = '{1'b1, 1'b1, SH_DATA, 1'b0, 1'b0, 1'b0, 9};
    tbl[2] = '{1'b1, 1'b1, 2'b00,   1'b0, 1'b1, 1'b0, 1};
    tbl[3] = '{1'b1, 1'b0, SH_DATA, 1'b1, 1'b0, 1'b0, 1};
    tbl[4] = '{1'b1, 1'b1, 2'b11,   1'b0, 1'b0, 1'b0, 4};
    tbl[5] = '{1'b1, 1'b0, SH_DATA, 1'b1, 1'b0, 1'b0, 1};
    tbl[6] = '{1'b1, 1'b1, 2'b11,   1'b0, 1'b0, 1'b0, 4};
    tbl[7] = '{1'b1, 1'b1, SH_CTRL, 1'b0, 1'b0, 1'b0, 63};
    tbl[8] = '{1'b1, 1'b1, SH_DATA, 1'b0, 1'b0, 1'b1, 1};

    do_reset();
    for (int i = 0; i < 9; i++)
      for (int r = 0; r < tbl[i].rep; r++)
        cyc(tbl[i].en, tbl[i].v, tbl[i].sh, tbl[i].sd, tbl[i].e_slip, tbl[i].e_lock, "tbl_row");

    // Clean lock with idle gaps that must not count as headers.
    do_reset();
    cyc(1'b1, 1'b0, SH_DATA, 1'b0, 1'b0, 1'b0, "clean_enable");
    for (int k = 1; k <= 64; k++) begin
      if (k % 8 == 0) cyc(1'b1, 1'b0, SH_DATA, 1'b0, 1'b0, 1'b0, "clean_idle");
      cyc(1'b1, 1'b1, SH_CTRL, 1'b0, 1'b0, (k == 64), "clean_hdr");
    end
    repeat (3) cyc(1'b1, 1'b0, SH_DATA, 1'b0, 1'b0, 1'b1, "clean_stay");

    // Lock hold: 15 invalid per window, alternately at window end and start.
    for (int w = 0; w < 10; w++)
      for (int j = 0; j < 64; j++) begin
        logic inv;
        inv = (w % 2 == 1) ? (j < 15) : (j >= 49);
        cyc(1'b1, 1'b1, inv ? ((j % 2 == 1) ? 2'b11 : 2'b00) : SH_DATA, 1'b0,
            1'b0, 1'b1, "hold_hdr");
      end

    // Coincident: 16th invalid is also the 64th header.
    do_reset();
    get_lock(1'b0);
    repeat (48) cyc(1'b1, 1'b1, SH_DATA, 1'b0, 1'b0, 1'b1, "coinc_valid");
    repeat (15) cyc(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, "coinc_inv");
    exp_loss = 8'd1;
    cyc(1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, "coinc_loss");
    cyc(1'b1, 1'b0, SH_DATA, 1'b0, 1'b0, 1'b0, "coinc_after");

    // Lock loss: 16 invalid interleaved with valid headers.
    do_reset();
    get_lock(1'b0);
    for (int j = 0; j <= 30; j++) begin
      if (j == 30) exp_loss = 8'd1;
      cyc(1'b1, 1'b1, (j % 2 == 0) ? 2'b00 : SH_DATA, 1'b0, (j == 30), (j != 30), "loss_hdr");
    end
    cyc(1'b1, 1'b0, SH_DATA, 1'b0, 1'b0, 1'b0, "loss_slip_one");
    cyc(1'b0, 1'b0, SH_DATA, 1'b0, 1'b0, 1'b0, "loss_disable_unlocked");

    // Lock-loss counter saturation via enable drops while locked.
    do_reset();
    for (int i = 1; i <= 256; i++) begin
      get_lock(1'b0);
      exp_loss = (exp_loss == 8'hFF) ? 8'hFF : exp_loss + 8'd1;
      cyc(1'b0, 1'b1, SH_DATA, 1'b0, 1'b0, 1'b0, "sat_disable");
    end

    // Reset during SLIP_WAIT, then a late slip_done must not matter.
    get_lock(1'b0);
    repeat (15) cyc(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, "rst_inv");
    cyc(1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, "rst_loss_sat");
    cyc(1'b1, 1'b0, SH_DATA, 1'b0, 1'b0, 1'b0, "rst_slip_wait");
    #2;
    rst_ref = 1'b0;
    #1;
    check("rst_async_clear", {slip_o, block_lock_o, lock_loss_cnt_o}, '0);
    exp_loss = 8'd0;
    @(negedge clk_ref);
    rst_ref = 1'b1;
    get_lock(1'b1);
    repeat (3) cyc(1'b1, 1'b0, SH_DATA, 1'b1, 1'b0, 1'b1, "rst_late_done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/g10_block_lock_ctrl.md
G10_BLOCK_LOCK_CTRL -- requirements
Module: g10_block_lock_ctrl

Interface
REQ-001 SHALL have parameter SH_CNT_MAX, default 64: number of headers per test window.
REQ-002 SHALL have parameter SH_INVALID_MAX, default 16: invalid headers per window that cause loss of lock.
REQ-003 SHALL have parameter SETTLE_BLOCKS, default 4: headers ignored after each completed slip.
REQ-004 SHALL have port clk_ref  input  1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_ref  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port enable_i  input  1: when low, the FSM is held in LOCK_INIT.
REQ-007 SHALL have port sh_valid_i  input  1: a new 66b block's sync header is presented this cycle.
REQ-008 SHALL have port sh_i  input  2: sync header bits; 2'b01 and 2'b10 are valid, 2'b00 and 2'b11 are invalid.
REQ-009 SHALL have port slip_o  output  1: one-cycle request to the gearbox to shift alignment by one bit.
REQ-010 SHALL have port slip_done_i  input  1: the gearbox has applied the requested slip.
REQ-011 SHALL have port block_lock_o  output  1: 66b block alignment is achieved.
REQ-012 SHALL have port lock_loss_cnt_o  output  8: saturating count of lock-to-unlock transitions.

Function
REQ-013 SHALL implement FSM states LOCK_INIT, TEST_SH, SLIP, SLIP_WAIT and SETTLE.
REQ-014 SHALL, in LOCK_INIT, clear sh_cnt, sh_invalid_cnt and block_lock_o, then move to TEST_SH on the next cycle when enable_i=1.
REQ-015 SHALL, in TEST_SH, increment sh_cnt on each sh_valid_i and also increment sh_invalid_cnt when sh_i is invalid; with sh_valid_i=0 the FSM holds state and counters.
REQ-016 SHALL, while unlocked, go to SLIP on the first invalid header.
REQ-017 SHALL, while unlocked, when sh_cnt reaches SH_CNT_MAX with sh_invalid_cnt=0, set block_lock_o=1 in the following cycle and clear both counters.
REQ-018 SHALL, while locked, go to SLIP when sh_invalid_cnt reaches SH_INVALID_MAX (the Nth invalid header), clear block_lock_o in the same cycle, and increment lock_loss_cnt_o, saturating at 255.
REQ-019 SHALL, while locked, clear both counters when sh_cnt reaches SH_CNT_MAX with sh_invalid_cnt<SH_INVALID_MAX; block_lock_o stays 1.
REQ-020 SHALL give precedence to the invalid-threshold check over the window-end check when both coincide on the same header.
REQ-021 SHALL, in SLIP, assert slip_o for exactly one cycle, clear both counters, and go to SLIP_WAIT.
REQ-022 SHALL, in SLIP_WAIT, ignore sh_valid_i and wait for slip_done_i; slip_done_i arriving in the same cycle as slip_o is ignored; slip_done_i=1 moves the FSM to SETTLE.
REQ-023 SHALL, in SETTLE, discard the next SETTLE_BLOCKS headers without counting them, then return to TEST_SH.
REQ-024 SHALL, when enable_i falls in any state, go to LOCK_INIT next cycle, with block_lock_o=0 and no slip_o; this counts as a lock loss if the block was locked.
REQ-025 SHALL size counters to $clog2 of their maximum plus 1; no counter wraps.

Reset
REQ-026 SHALL, with rst_ref=0, immediately force state LOCK_INIT, slip_o=0, block_lock_o=0, lock_loss_cnt_o=0 and all counters to 0.
REQ-027 SHALL, after rst_ref deasserts, leave LOCK_INIT no earlier than the first clk_ref edge.
REQ-028 SHALL, on reset during SLIP_WAIT, abandon the pending slip; a late slip_done_i is then ignored.

Structure
REQ-029 SHALL place the FSM state enum, the sync-header constants SH_DATA=2'b01 and SH_CTRL=2'b10, and the default window constants in package g10_pcs_pkg.
REQ-030 SHALL be a single module, with no sub-module; the counters are inline.

Verification
REQ-031 SHALL verify clean lock: 64 valid headers after enable -> block_lock_o=1 one cycle after the 64th, slip_o never asserted.
REQ-032 SHALL verify slip on unlock: invalid header at header 10 -> one slip_o pulse; slip_done_i 5 cycles later -> 4 headers discarded, then counting restarts from 0.
REQ-033 SHALL verify lock loss: locked, then 16 invalid headers within one 64-header window -> block_lock_o=0 on the 16th, slip_o pulse, lock_loss_cnt_o=1.
REQ-034 SHALL verify lock hold: locked, 15 invalid headers per window for 10 windows -> block_lock_o stays 1, no slip_o.
REQ-035 SHALL verify coincident events: the 16th invalid header is also the 64th header -> lock lost (threshold wins).
REQ-036 SHALL verify reset mid-operation: rst_ref low during SLIP_WAIT -> outputs 0 immediately; a later slip_done_i is ignored; lock loss 256 times -> lock_loss_cnt_o=255.
